// File: rtl/btn_conditioner.sv
// Button/switch conditioner feeding the Fibonacci/timer top.
// Each raw button is synchronized, debounced and turned into a one-cycle command pulse.
// Simultaneous presses are arbitrated with a fixed priority. The program switches are captured
// into prog only when an update command fires.
// Optional feature: define HOLD_REPEAT_EN to re-issue a press every REPEAT_CYCLES while a button
// stays held.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  input  logic [2:0] sw_in,
  output logic       start_f,
  output logic       start_t,
  output logic       stop_f_t,
  output logic       update,
  output logic [2:0] prog,
  output logic       dropped
);

  // Button bit positions.
  localparam int unsigned BtnStartF = 0;
  localparam int unsigned BtnStartT = 1;
  localparam int unsigned BtnStop   = 2;
  localparam int unsigned BtnUpdate = 3;

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Both counters compare against PARAM-1, so anything below 2 breaks the timing.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  logic [3:0]      btn_m, btn_s;
  logic [2:0]      sw_m, sw_s;
  logic [3:0]      stable;
  logic [CntW-1:0] cnt [4];
  logic [3:0]      rise;
  logic [3:0]      event_req;
  logic [3:0]      win;
  logic            lost;

  // Two-flop synchronizers for all asynchronous inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_m <= '0;
      btn_s <= '0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
      sw_m  <= sw_in;
      sw_s  <= sw_m;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntMax) begin
          stable[i] <= btn_s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

  // A press is the edge where a debounced level is about to go 0 -> 1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = btn_s[i] & ~stable[i] & (cnt[i] == CntMax);
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_CYCLES);
  localparam logic [RptW-1:0] RptMax = RptW'(REPEAT_CYCLES - 1);

  logic [RptW-1:0] rcnt [4];
  logic [3:0]      rep;

  // Repeat timer runs while the debounced level is high; it restarts on every press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!stable[i] || (rcnt[i] == RptMax)) begin
          rcnt[i] <= '0;
        end else begin
          rcnt[i] <= rcnt[i] + RptW'(1);
        end
      end
    end
  end

  // A repeat is suppressed once the synchronized input has already let go, so a button that is
  // being released never emits a trailing pulse during its release debounce.
  always_comb begin
    rep = '0;
    for (int i = 0; i < 4; i++) begin
      rep[i] = stable[i] & btn_s[i] & (rcnt[i] == RptMax);
    end
    event_req = rise | rep;
  end
`else
  // Without repeat, only the initial press raises a request.
  always_comb begin
    event_req = rise;
  end
`endif

  // Fixed-priority arbitration: stop > update > start_f > start_t; losers are discarded.
  always_comb begin
    win = '0;
    if (event_req[BtnStop]) begin
      win[BtnStop] = 1'b1;
    end else if (event_req[BtnUpdate]) begin
      win[BtnUpdate] = 1'b1;
    end else if (event_req[BtnStartF]) begin
      win[BtnStartF] = 1'b1;
    end else if (event_req[BtnStartT]) begin
      win[BtnStartT] = 1'b1;
    end
    lost = |(event_req & ~win);
  end

  // Registered command pulses; prog is captured on the same edge that raises update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_f  <= 1'b0;
      start_t  <= 1'b0;
      stop_f_t <= 1'b0;
      update   <= 1'b0;
      dropped  <= 1'b0;
      prog     <= '0;
    end else begin
      start_f  <= win[BtnStartF];
      start_t  <= win[BtnStartT];
      stop_f_t <= win[BtnStop];
      update   <= win[BtnUpdate];
      dropped  <= lost;
      if (win[BtnUpdate]) begin
        prog <= sw_s;
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge just before.
// Time index t counts falling edges from the start of a scenario: a level driven at t is
// first sampled by the following rising edge, so a clean press driven at t=0 shows its
// pulse at t=6.
module tb_btn_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned R = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_in = '0;
  logic [2:0] sw_in = '0;
  logic       start_f, start_t, stop_f_t, update, dropped;
  logic [2:0] prog;

  int errors = 0;
  int checks = 0;

  // Per-scenario observation log (pulse times per output).
  int         q_sf[$], q_st[$], q_sp[$], q_up[$], q_dr[$];
  int         multi;
  int         prog_bad;
  logic [2:0] prog_prev;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .sw_in   (sw_in),
    .start_f (start_f),
    .start_t (start_t),
    .stop_f_t(stop_f_t),
    .update  (update),
    .prog    (prog),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  task automatic obs_clear();
    q_sf.delete(); q_st.delete(); q_sp.delete(); q_up.delete(); q_dr.delete();
    multi     = 0;
    prog_bad  = 0;
    prog_prev = prog;
  endtask

  // Log which outputs are high at this sample; no judging here.
  task automatic observe(input int t);
    if (start_f)  q_sf.push_back(t);
    if (start_t)  q_st.push_back(t);
    if (stop_f_t) q_sp.push_back(t);
    if (update)   q_up.push_back(t);
    if (dropped)  q_dr.push_back(t);
    if (int'(start_f) + int'(start_t) + int'(stop_f_t) + int'(update) > 1) multi++;
    if (prog !== prog_prev && update !== 1'b1) prog_bad++;
    prog_prev = prog;
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic test_reset();
    int total;
    rst = 1'b0;
    btn_in = '0;
    sw_in = 3'b101;
    repeat (3) @(negedge clk);
    checks++;
    if ({start_f, start_t, stop_f_t, update, dropped} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {start_f, start_t, stop_f_t, update, dropped});
    end
    checks++;
    if (prog !== 3'b000) begin
      errors++;
      $display("FAIL reset_prog: got %b expected 000", prog);
    end
    obs_clear();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      observe(t);
      if (t == 0) rst = 1'b1;
    end
    total = q_sf.size() + q_st.size() + q_sp.size() + q_up.size();
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d pulses expected 0", total);
    end
    checks++;
    if (q_dr.size() != 0) begin
      errors++;
      $display("FAIL idle_dropped: got %0d expected 0", q_dr.size());
    end
    checks++;
    if (prog !== 3'b000) begin
      errors++;
      $display("FAIL idle_prog: got %b expected 000", prog);
    end
  endtask

  task automatic test_single_press();
    int exp_n;
    int others;
`ifdef HOLD_REPEAT_EN
    exp_n = 3;  // initial at t=6, repeats at t=14 and t=22
`else
    exp_n = 1;
`endif
    obs_clear();
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      observe(t);
      btn_in[0] = (t < 20);
    end
    checks++;
    if (q_sf.size() != exp_n) begin
      errors++;
      $display("FAIL press_count: got %0d start_f pulses expected %0d", q_sf.size(), exp_n);
    end
    checks++;
    if (first(q_sf) != 6) begin
      errors++;
      $display("FAIL press_latency: got t=%0d expected t=6", first(q_sf));
    end
    others = q_st.size() + q_sp.size() + q_up.size() + q_dr.size();
    checks++;
    if (others != 0) begin
      errors++;
      $display("FAIL press_others: got %0d other pulses expected 0", others);
    end
  endtask

  task automatic test_update_prog();
    logic [2:0] at_update;
    at_update = 3'bxxx;
    sw_in = 3'b011;
    repeat (4) @(negedge clk);
    obs_clear();
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      observe(t);
      if (update) at_update = prog;
      btn_in[3] = (t < 10);
    end
    checks++;
    if (q_up.size() != 1 || first(q_up) != 6) begin
      errors++;
      $display("FAIL update_pulse: got %0d pulses first t=%0d expected 1 at t=6",
               q_up.size(), first(q_up));
    end
    checks++;
    if (at_update !== 3'b011) begin
      errors++;
      $display("FAIL update_prog_same_cycle: got %b expected 011", at_update);
    end
    checks++;
    if (prog_bad != 0) begin
      errors++;
      $display("FAIL prog_changed_off_update: got %0d changes expected 0", prog_bad);
    end
    sw_in = 3'b000;
    repeat (12) @(negedge clk);
    checks++;
    if (prog !== 3'b011) begin
      errors++;
      $display("FAIL prog_hold: got %b expected 011", prog);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b01101;  // t0..t4 = 1,0,1,1,0
    obs_clear();
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      observe(t);
      if (t < 5) btn_in[0] = pat[t];
      else btn_in[0] = (t < 15);
    end
    // Final 0->1 sampled at the edge after t=5; pulse six edges later, seen at t=11.
    checks++;
    if (q_sf.size() != 1 || first(q_sf) != 11) begin
      errors++;
      $display("FAIL bounce_pulse: got %0d pulses first t=%0d expected 1 at t=11",
               q_sf.size(), first(q_sf));
    end
  endtask

  task automatic test_simultaneous();
    obs_clear();
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      observe(t);
      btn_in[2] = (t < 10);
      btn_in[1] = (t < 10);
    end
    checks++;
    if (q_sp.size() != 1 || first(q_sp) != 6) begin
      errors++;
      $display("FAIL arb_stop: got %0d pulses first t=%0d expected 1 at t=6",
               q_sp.size(), first(q_sp));
    end
    checks++;
    if (q_st.size() != 0) begin
      errors++;
      $display("FAIL arb_start_t: got %0d pulses expected 0", q_st.size());
    end
    checks++;
    if (q_dr.size() != 1 || first(q_dr) != 6) begin
      errors++;
      $display("FAIL arb_dropped: got %0d flags first t=%0d expected 1 at t=6",
               q_dr.size(), first(q_dr));
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL arb_onehot: got %0d multi-pulse cycles expected 0", multi);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] prog_in_rst;
    prog_in_rst = 3'bxxx;
    obs_clear();
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      observe(t);
      if (t == 4) prog_in_rst = prog;
      btn_in[3] = (t < 4);
      if (t == 3) rst = 1'b0;
      if (t == 5) rst = 1'b1;
    end
    checks++;
    if (prog_in_rst !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_async_prog: got %b expected 000", prog_in_rst);
    end
    checks++;
    if (q_up.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_update: got %0d pulses expected 0", q_up.size());
    end
    checks++;
    if (prog !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_prog: got %b expected 000", prog);
    end
  endtask

  task automatic test_held_through_reset();
    rst = 1'b0;
    btn_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    obs_clear();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      observe(t);
      if (t == 0) rst = 1'b1;
      btn_in[0] = (t < 8);
    end
    checks++;
    if (q_sf.size() != 1 || first(q_sf) != 6) begin
      errors++;
      $display("FAIL held_reset_pulse: got %0d pulses first t=%0d expected 1 at t=6",
               q_sf.size(), first(q_sf));
    end
  endtask

`ifdef HOLD_REPEAT_EN
  task automatic test_hold_repeat();
    int exp_t[5];
    exp_t = '{6, 14, 22, 30, 38};
    obs_clear();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      observe(t);
      btn_in[1] = (t < 40);
    end
    checks++;
    if (q_st.size() != 5) begin
      errors++;
      $display("FAIL repeat_count: got %0d start_t pulses expected 5", q_st.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < q_st.size()) begin
        checks++;
        if (q_st[i] != exp_t[i]) begin
          errors++;
          $display("FAIL repeat_time[%0d]: got t=%0d expected t=%0d", i, q_st[i], exp_t[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_update_prog();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_held_through_reset();
`ifdef HOLD_REPEAT_EN
    test_hold_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
